// File: rtl/pll_ps_ctrl.sv
// -----------------------------------------------------------------------------
// pll_ps_ctrl
//   Sequencer for the PLL dynamic control pins. It brings the PLL out of reset,
//   qualifies lock, recovers from lock loss, and turns single phase-shift
//   requests into spaced PSPULSE trains. It also tracks a per-output phase
//   position.
//
// Ports
//   clk          reference clock (same as PLL clkin)
//   rst          asynchronous active-high reset
//   pll_lock     raw PLL LOCK, asynchronous to clk
//   pll_reset    PLL RESET
//   pll_pssel    PLL PSSEL (target output of the current train)
//   pll_psdir    PLL PSDIR (1 = advance)
//   pll_pspulse  PLL PSPULSE
//   req_valid    phase-shift request; held by requester until accepted
//   req_ready    high only while idle and locked; accept = valid & ready
//   req_sel      target output
//   req_dir      1 = advance (+1 per step), 0 = retard (-1 per step)
//   req_steps    number of pulses, 0..255
//   done         one-clock completion pulse (also for error/abort)
//   err          one-clock pulse with done: bad sel or lock-loss abort
//   locked       qualified lock
//   relock_cnt   lock-loss recoveries since rst, saturating
//   phase_pos    per-output phase position, output i at slice i
//
// All PLL-facing and status outputs are registered from the current state,
// so they appear one clock after the state that produces them. The lock-loss
// path overrides them on the same edge that leaves for PLL_RST.
// -----------------------------------------------------------------------------
module pll_ps_ctrl #(
  parameter int N_OUT        = 4,
  parameter int POS_MOD      = 64,
  parameter int RST_CYCLES   = 32,
  parameter int LOCK_FILT    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_HI     = 4,
  parameter int PULSE_GAP    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pll_lock,
  output logic                             pll_reset,
  output logic [2:0]                       pll_pssel,
  output logic                             pll_psdir,
  output logic                             pll_pspulse,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [2:0]                       req_sel,
  input  logic                             req_dir,
  input  logic [7:0]                       req_steps,
  output logic                             done,
  output logic                             err,
  output logic                             locked,
  output logic [7:0]                       relock_cnt,
  output logic [N_OUT*$clog2(POS_MOD)-1:0] phase_pos
);

  localparam int PW   = $clog2(POS_MOD);
  localparam int M1   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2   = (SETUP_CYC > PULSE_HI) ? SETUP_CYC : PULSE_HI;
  localparam int M3   = (M2 > PULSE_GAP) ? M2 : PULSE_GAP;
  localparam int M4   = (M1 > M3) ? M1 : M3;
  localparam int CMAX = (M4 > LOCK_FILT) ? M4 : LOCK_FILT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_IDLE,
    S_SETUP,
    S_PULSE_H,
    S_PULSE_L,
    S_DONE
  } state_t;

  // Lock synchroniser
  logic lock_meta_reg, lock_s_reg;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;     // per-state dwell / lock timeout
  logic [CW-1:0] filt_reg, filt_next;   // consecutive lock_s clocks
  logic [2:0]    sel_reg, sel_next;
  logic          dir_reg, dir_next;
  logic [7:0]    rem_reg, rem_next;     // pulses still to issue
  logic          bad_reg, bad_next;     // latched sel >= N_OUT
  logic          deg_reg, deg_next;     // request completes without a train

  logic          pll_reset_reg, pll_reset_next;
  logic [2:0]    pssel_reg, pssel_next;
  logic          psdir_reg, psdir_next;
  logic          pspulse_reg, pspulse_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          locked_reg, locked_next;
  logic [7:0]    relock_reg, relock_next;

  logic          lock_loss, in_flight, accept;
  logic          pos_step, pos_clear;

  assign req_ready = (state_reg == S_IDLE) && lock_s_reg;
  assign accept    = req_valid && req_ready;
  assign in_flight = state_reg inside {S_SETUP, S_PULSE_H, S_PULSE_L, S_DONE};
  assign lock_loss = !lock_s_reg &&
                     (state_reg inside {S_IDLE, S_SETUP, S_PULSE_H, S_PULSE_L, S_DONE});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      state_reg     <= S_PLL_RST;
      cnt_reg       <= '0;
      filt_reg      <= '0;
      sel_reg       <= '0;
      dir_reg       <= 1'b0;
      rem_reg       <= '0;
      bad_reg       <= 1'b0;
      deg_reg       <= 1'b0;
      pll_reset_reg <= 1'b1;
      pssel_reg     <= '0;
      psdir_reg     <= 1'b0;
      pspulse_reg   <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      locked_reg    <= 1'b0;
      relock_reg    <= '0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      filt_reg      <= filt_next;
      sel_reg       <= sel_next;
      dir_reg       <= dir_next;
      rem_reg       <= rem_next;
      bad_reg       <= bad_next;
      deg_reg       <= deg_next;
      pll_reset_reg <= pll_reset_next;
      pssel_reg     <= pssel_next;
      psdir_reg     <= psdir_next;
      pspulse_reg   <= pspulse_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      locked_reg    <= locked_next;
      relock_reg    <= relock_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    filt_next   = filt_reg;
    sel_next    = sel_reg;
    dir_next    = dir_reg;
    rem_next    = rem_reg;
    bad_next    = bad_reg;
    deg_next    = deg_reg;
    locked_next = locked_reg;
    relock_next = relock_reg;
    pos_step    = 1'b0;
    pos_clear   = 1'b0;

    case (state_reg)
      S_PLL_RST: begin
        if (cnt_reg == CW'(RST_CYCLES - 1)) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
          filt_next  = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Qualification wins over a timeout landing on the same clock.
        if (lock_s_reg && (filt_reg == CW'(LOCK_FILT - 1))) begin
          state_next  = S_IDLE;
          locked_next = 1'b1;
        end else if (cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
          state_next = S_PLL_RST;
          cnt_next   = '0;
        end else begin
          cnt_next  = cnt_reg + 1'b1;
          filt_next = lock_s_reg ? filt_reg + 1'b1 : '0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          sel_next = req_sel;
          dir_next = req_dir;
          rem_next = req_steps;
          bad_next = (int'(req_sel) >= N_OUT);
          deg_next = (int'(req_sel) >= N_OUT) || (req_steps == 8'd0);
          cnt_next = '0;
          if ((int'(req_sel) >= N_OUT) || (req_steps == 8'd0))
            state_next = S_DONE;
          else
            state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_reg == CW'(SETUP_CYC - 1)) begin
          state_next = S_PULSE_H;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PULSE_H: begin
        if (cnt_reg == CW'(PULSE_HI - 1)) begin
          state_next = S_PULSE_L;
          cnt_next   = '0;
          pos_step   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PULSE_L: begin
        if (cnt_reg == CW'(PULSE_GAP - 1)) begin
          cnt_next = '0;
          if (rem_reg == 8'd1) begin
            state_next = S_DONE;
          end else begin
            rem_next   = rem_reg - 8'd1;
            state_next = S_PULSE_H;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_PLL_RST;
        cnt_next   = '0;
      end
    endcase

    // Lock loss preempts everything; a pulse cut short never updates position.
    if (lock_loss) begin
      state_next  = S_PLL_RST;
      cnt_next    = '0;
      locked_next = 1'b0;
      relock_next = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 8'd1;
      pos_step    = 1'b0;
      pos_clear   = 1'b1;
    end
  end

  // Registered output decode from the current state.
  always_comb begin
    pll_reset_next = (state_reg == S_PLL_RST);
    pspulse_next   = (state_reg == S_PULSE_H) && !lock_loss;
    pssel_next     = '0;
    psdir_next     = 1'b0;
    case (state_reg)
      S_SETUP, S_PULSE_H, S_PULSE_L: begin
        pssel_next = sel_reg;
        psdir_next = dir_reg;
      end
      S_DONE: begin
        // Hold through the done pulse; degenerate requests never drive the pins.
        pssel_next = deg_reg ? 3'd0 : sel_reg;
        psdir_next = deg_reg ? 1'b0 : dir_reg;
      end
      default: ;
    endcase
    if (lock_loss) begin
      pssel_next = '0;
      psdir_next = 1'b0;
    end
    done_next = (state_reg == S_DONE) || (lock_loss && in_flight);
    err_next  = ((state_reg == S_DONE) && bad_reg) || (lock_loss && in_flight);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_pos
      logic [PW-1:0] pos_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pos_reg <= '0;
        else if (pos_clear)
          pos_reg <= '0;
        else if (pos_step && (sel_reg == 3'(gi)))
          pos_reg <= dir_reg ? pos_reg + 1'b1 : pos_reg - 1'b1;  // wraps mod POS_MOD
      end
      assign phase_pos[gi*PW +: PW] = pos_reg;
    end
  endgenerate

  assign pll_reset   = pll_reset_reg;
  assign pll_pssel   = pssel_reg;
  assign pll_psdir   = psdir_reg;
  assign pll_pspulse = pspulse_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign locked      = locked_reg;
  assign relock_cnt  = relock_reg;

endmodule

// File: doc/pll_ps_ctrl.md
Name: pll_ps_ctrl

Overview:
Sequencer for the GPIO PLL's dynamic control pins: PLL reset, lock qualification and dynamic phase shift (PSSEL/PSDIR/PSPULSE). It brings the PLL up after reset, re-lock-recovers on lock loss, and serialises phase-shift requests from a single requester into correctly spaced PSPULSE trains. It also keeps a per-output phase position that is software-visible. It sits between the PLL wrapper and the board control logic, in the same clock domain as the PLL reference clock.

Parameters:
N_OUT, 4, number of phase-shiftable outputs (CLKOUT0..N_OUT-1); maximum 7
POS_MOD, 64, phase positions per output; position wraps modulo POS_MOD; power of two
RST_CYCLES, 32, pll_reset high time in clocks
LOCK_FILT, 16, consecutive synced-lock-high clocks required to declare lock
LOCK_TIMEOUT, 4096, clocks allowed in WAIT_LOCK before re-resetting the PLL
SETUP_CYC, 2, clocks pssel/psdir are stable before the first pulse
PULSE_HI, 4, pll_pspulse high time in clocks
PULSE_GAP, 4, pll_pspulse low time after each pulse

Ports:
clk  in  1  reference clock, same as PLL clkin
rst  in  1  asynchronous, active-high reset
pll_lock  in  1  raw PLL LOCK (asynchronous)
pll_reset  out  1  to PLL RESET
pll_pssel  out  3  to PLL PSSEL
pll_psdir  out  1  to PLL PSDIR
pll_pspulse  out  1  to PLL PSPULSE
req_valid  in  1  phase-shift request
req_ready  out  1  request accepted when valid&ready
req_sel  in  3  target output
req_dir  in  1  1 = advance (+1 per step), 0 = retard (-1)
req_steps  in  8  number of pulses, 0..255
done  out  1  one-clock pulse at request completion (including error/abort)
err  out  1  one-clock pulse with done: bad sel or lock-loss abort
locked  out  1  qualified lock
relock_cnt  out  8  lock-loss recoveries since rst, saturates at 255
phase_pos  out  N_OUT*log2(POS_MOD)  per-output position; output i at slice i

Behaviour:
- Reset values: pll_reset=1, pll_pssel=0, pll_psdir=0, pll_pspulse=0, req_ready=0, done=0, err=0, locked=0, relock_cnt=0, phase_pos=all 0. rst is async assert; state leaves reset on the first clk edge after deassertion.
- Sync pll_lock through a 2-flop synchroniser (lock_s). All lock decisions use lock_s.
- States:
  - PLL_RST: pll_reset=1 for RST_CYCLES clocks, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_reset=0. Count consecutive lock_s=1 clocks; lock_s=0 clears the count. Reaching LOCK_FILT goes to IDLE and sets locked=1. If LOCK_TIMEOUT elapses first, go to PLL_RST.
  - IDLE: req_ready=1 only here. On accept, latch sel, dir and steps.
    - sel>=N_OUT: next clock done=1, err=1, no pulses, back to IDLE.
    - steps=0: next clock done=1, err=0, back to IDLE.
    - Otherwise go to SETUP.
  - SETUP: pll_pssel=sel and pll_psdir=dir for SETUP_CYC clocks. pssel/psdir hold these values until done.
  - PULSE_H: pll_pspulse=1 for PULSE_HI clocks. On leaving, phase_pos[sel] updates ±1 modulo POS_MOD (63+1→0, 0−1→63).
  - PULSE_L: pll_pspulse=0 for PULSE_GAP clocks. Decrement the remaining count; if nonzero go to PULSE_H, else go to DONE.
  - DONE: done=1 for one clock, then IDLE.
- Latency from accept to done for steps=S≥1: 1+SETUP_CYC+S*(PULSE_HI+PULSE_GAP) clocks. With defaults and S=1, done is 11 clocks after the accept edge.
- Lock loss: lock_s=0 in IDLE, SETUP, PULSE_H, PULSE_L or DONE does the following:
  - locked=0; increment relock_cnt (saturating at 255).
  - If a request is in flight, emit done=1, err=1 in the same clock.
  - Force pll_pspulse=0 immediately.
  - Clear all phase_pos to 0 (the PLL reverts to its static phase).
  - Go to PLL_RST.
  - A pulse cut short does not update phase_pos.
- req_valid while not ready is ignored. There is no queueing; the requester holds valid.
- rst mid-pulse: all outputs return to reset values asynchronously.

Test Plan:
- Bring-up: deassert rst, pll_lock=1 from clock 5 → pll_reset high for exactly 32 clocks; locked=1 once lock_s has been high 16 consecutive clocks; req_ready=1.
- Single shift: sel=2, dir=1, steps=3 → pssel=2 and psdir=1 stable throughout; 3 pulses of 4 high / 4 low; done 27 clocks after accept; phase_pos[2]=3.
- Wrap: sel=0, dir=0, steps=1 from pos 0 → phase_pos[0]=63; then dir=1, steps=1 → 0.
- Degenerate requests: steps=0 → done next clock, err=0, no pulse. sel=5 → done+err next clock, no pulse, no phase_pos change.
- Lock loss mid-train: drop pll_lock during the 2nd pulse of steps=5 → pspulse=0 within the synchroniser delay; done+err pulse; relock_cnt=1; phase_pos all 0; pll_reset 32 clocks; relock once lock returns.
- Lock timeout: hold pll_lock=0 → WAIT_LOCK re-enters PLL_RST every 4096+32 clocks; locked stays 0; req_ready stays 0.
